alu: RTL and testbench

Combinational 32-bit arithmetic/logic unit for the single-cycle CPU datapath. It computes add, subtract, AND and OR of two operands and produces the ARM-style condition flags N, Z, C and V. It sits between the register-file/immediate operand muxes and the result mux. It also holds a registered copy of the flags (NZCV) for the condition-check logic.

---
 rtl/alu_if.sv | 22 ++
 rtl/alu.sv | 55 +++++
 tb/tb_alu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand, control and result bundle between the datapath operand muxes and the ALU.
interface alu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [1:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Negative;
  logic        Overflow;
  logic        Carry;
  logic [3:0]  Flags;

  modport master (
    output SrcA, SrcB, ALUControl,
    input  ALUResult, Zero, Negative, Overflow, Carry, Flags
  );

  modport slave (
    input  SrcA, SrcB, ALUControl,
    output ALUResult, Zero, Negative, Overflow, Carry, Flags
  );
endinterface

// File: rtl/alu.sv
// 32-bit ADD/SUB/AND/OR unit with combinational NZCV flags and a registered NZCV copy.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  alu_op_e     op;
  logic [31:0] opb;
  logic [32:0] sum;
  logic [31:0] result;
  logic        carry;
  logic        overflow;

  assign op = alu_op_e'(bus.ALUControl);

  // Subtract shares the adder: A + ~B + 1, with the carry-in taken from ALUControl[0].
  assign opb = bus.ALUControl[0] ? ~bus.SrcB : bus.SrcB;
  assign sum = {1'b0, bus.SrcA} + {1'b0, opb} + {32'b0, bus.ALUControl[0]};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result   = sum[31:0];
        carry    = sum[32];
        overflow = ~(bus.SrcA[31] ^ bus.SrcB[31] ^ bus.ALUControl[0])
                   & (bus.SrcA[31] ^ sum[31]);
      end
      OP_AND: result = bus.SrcA & bus.SrcB;
      OP_OR:  result = bus.SrcA | bus.SrcB;
    endcase
  end

  assign bus.ALUResult = result;
  assign bus.Negative  = result[31];
  assign bus.Zero      = (result == '0);
  assign bus.Carry     = carry;
  assign bus.Overflow  = overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.Flags <= '0;
    else        bus.Flags <= {result[31], (result == '0), carry, overflow};
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: an arithmetic reference model checked every cycle plus literal expectations.
module tb_alu;
  logic clk;
  logic rst_n;
  alu_if bus ();

  alu u_alu (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned vectors;
  int unsigned miscompares;
  logic        run;
  logic [3:0]  mflags;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {N,Z,C,V, result} from integer arithmetic on the operands.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    longint unsigned ua, ub, us;
    longint          sa, sb, ss;
    logic [31:0]     r;
    logic            c, v;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      2'b00: begin
        us = ua + ub;
        r  = us[31:0];
        c  = (us > 64'h0000_0000_FFFF_FFFF);
        ss = sa + sb;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      2'b01: begin
        r  = a - b;
        c  = (ua >= ub);
        ss = sa - sb;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'h0), c, v, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mflags = 4'b0000;
    else begin
      logic [35:0] m;
      m = model(bus.SrcA, bus.SrcB, bus.ALUControl);
      mflags = m[35:32];
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [35:0] m;
      m = model(bus.SrcA, bus.SrcB, bus.ALUControl);
      check("result",   bus.ALUResult,                {m[31:0]});
      check("nzcv",     {28'b0, bus.Negative, bus.Zero, bus.Carry, bus.Overflow},
                        {28'b0, m[35:32]});
      check("flags_reg", {28'b0, bus.Flags},          {28'b0, mflags});
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] r;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] m;
    vectors     = 0;
    miscompares = 0;
    run         = 1'b0;
    rst_n       = 1'b0;
    bus.SrcA       = 32'h0;
    bus.SrcB       = 32'h0;
    bus.ALUControl = 2'b00;

    vecs.push_back('{32'h0000_0004, 32'h0000_0005, 2'b00, 32'h0000_0009, 4'b0000});
    vecs.push_back('{32'h0000_0004, 32'h0000_0005, 2'b01, 32'hFFFF_FFFF, 4'b1000});
    vecs.push_back('{32'h0000_0004, 32'h0000_0005, 2'b10, 32'h0000_0004, 4'b0000});
    vecs.push_back('{32'h0000_0004, 32'h0000_0005, 2'b11, 32'h0000_0005, 4'b0000});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b0110});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b0011});
    vecs.push_back('{32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 4'b0110});
    vecs.push_back('{32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 32'h0000_0000, 4'b0100});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 2'b11, 32'h8000_0001, 4'b1000});
    vecs.push_back('{32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 4'b1000});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000, 4'b0111});
    vecs.push_back('{32'h1234_5678, 32'h0000_1111, 2'b01, 32'h1234_4567, 4'b0010});

    #1 run = 1'b1;

    // Reset held across several edges with a non-zero-flag operation applied.
    bus.SrcA = 32'h0000_0005; bus.SrcB = 32'h0000_0005; bus.ALUControl = 2'b01;
    repeat (3) begin
      @(posedge clk); #1;
      check("flags_in_reset", {28'b0, bus.Flags}, 32'h0);
    end

    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("flags_first_capture", {28'b0, bus.Flags}, 32'h6);

    #2 rst_n = 1'b0;
    #1 check("flags_async_clear", {28'b0, bus.Flags}, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      bus.SrcA = vecs[i].a; bus.SrcB = vecs[i].b; bus.ALUControl = vecs[i].op;
      #1;
      m = model(vecs[i].a, vecs[i].b, vecs[i].op);
      check("model_lit_result", m[31:0], vecs[i].r);
      check("model_lit_nzcv", {28'b0, m[35:32]}, {28'b0, vecs[i].nzcv});
      check("dut_lit_result", bus.ALUResult, vecs[i].r);
      check("dut_lit_nzcv", {28'b0, bus.Negative, bus.Zero, bus.Carry, bus.Overflow},
            {28'b0, vecs[i].nzcv});
      @(posedge clk); #1;
      check("dut_lit_flags", {28'b0, bus.Flags}, {28'b0, vecs[i].nzcv});
    end

    @(negedge clk); #1;
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
